// File: rtl/wt_mem_resp_pkg.sv
// Shared types and helpers for the write-through memory responder.
//   req_type_e   : request/return type encoding (LOAD, IFILL, STORE, AMO)
//   amo_op_e     : atomic operation encoding (SWAP, ADD, AND, OR)
//   state_e      : responder FSM states
//   wt_mem_req_t : latched request fields
//   lane_base / byte_mask / bit_mask : size-aligned lane helpers for a 64-bit word
package wt_mem_resp_pkg;

    typedef enum logic [1:0] {
        REQ_LOAD  = 2'd0,
        REQ_IFILL = 2'd1,
        REQ_STORE = 2'd2,
        REQ_AMO   = 2'd3
    } req_type_e;

    typedef enum logic [1:0] {
        AMO_SWAP = 2'd0,
        AMO_ADD  = 2'd1,
        AMO_AND  = 2'd2,
        AMO_OR   = 2'd3
    } amo_op_e;

    typedef enum logic [2:0] {
        ST_CLEAR,
        ST_IDLE,
        ST_WAIT,
        ST_ACCESS,
        ST_ACCESS_HI,
        ST_RESP
    } state_e;

    // Wide enough for any practical physical address; only the offset and
    // index bits are consumed, the rest simply ride along.
    localparam int unsigned ReqAddrWidth = 64;

    typedef struct packed {
        req_type_e                rtype;
        logic [1:0]               tid;
        logic [ReqAddrWidth-1:0]  addr;
        logic [1:0]               size;
        amo_op_e                  amo_op;
        logic [63:0]              data;
    } wt_mem_req_t;

    // First byte lane of the access inside its 64-bit word. Misaligned
    // offsets are truncated down to the size alignment.
    function automatic logic [2:0] lane_base(input logic [1:0] size, input logic [2:0] offset);
        logic [2:0] base;
        case (size)
            2'd0:    base = offset;
            2'd1:    base = {offset[2:1], 1'b0};
            2'd2:    base = {offset[2], 2'b00};
            default: base = 3'd0;
        endcase
        return base;
    endfunction

    // Byte enables inside the 64-bit word for a (1 << size)-byte access.
    function automatic logic [7:0] byte_mask(input logic [1:0] size, input logic [2:0] offset);
        logic [7:0] ones;
        case (size)
            2'd0:    ones = 8'h01;
            2'd1:    ones = 8'h03;
            2'd2:    ones = 8'h0f;
            default: ones = 8'hff;
        endcase
        return ones << lane_base(size, offset);
    endfunction

    // Byte enables expanded to one bit per data bit.
    function automatic logic [63:0] bit_mask(input logic [1:0] size, input logic [2:0] offset);
        logic [7:0]  be;
        logic [63:0] bm;
        be = byte_mask(size, offset);
        for (int b = 0; b < 8; b++) begin
            bm[b*8 +: 8] = {8{be[b]}};
        end
        return bm;
    endfunction

endpackage

// File: rtl/wt_mem_resp_amo_alu.sv
// Combinational atomic-operation unit.
//   op       : SWAP / ADD / AND / OR
//   size     : log2 bytes of the operation (0..3)
//   old_val  : current memory value, shifted down to bit 0
//   operand  : request operand, shifted down to bit 0
//   result   : new value, bits above 2^(size+3) forced to zero
// ADD wraps inside the operand size because the carry out is masked away.
module wt_mem_resp_amo_alu
    import wt_mem_resp_pkg::*;
(
    input  amo_op_e     op,
    input  logic [1:0]  size,
    input  logic [63:0] old_val,
    input  logic [63:0] operand,
    output logic [63:0] result
);

    logic [63:0] size_mask;
    logic [63:0] raw;

    // NOTE: every output of a combinational block is given a default first, so
    // no path leaves it unassigned and no latch is inferred.
    always_comb begin
        size_mask = 64'hffff_ffff_ffff_ffff;
        raw       = operand;
        case (size)
            2'd0:    size_mask = 64'h0000_0000_0000_00ff;
            2'd1:    size_mask = 64'h0000_0000_0000_ffff;
            2'd2:    size_mask = 64'h0000_0000_ffff_ffff;
            default: size_mask = 64'hffff_ffff_ffff_ffff;
        endcase
        case (op)
            AMO_SWAP: raw = operand;
            AMO_ADD:  raw = old_val + operand;
            AMO_AND:  raw = old_val & operand;
            AMO_OR:   raw = old_val | operand;
            default:  raw = operand;
        endcase
        result = raw & size_mask;
    end

endmodule

// File: rtl/wt_mem_responder.sv
// Memory-side responder for the write-through L1 request/return link.
// Accepts one request at a time, waits Latency cycles, services it from a
// line-organised storage array and holds the response until acknowledged.
// Ports:
//   clk_i, rst_i          : clock, asynchronous active-high reset
//   req_val_i / req_ack_o : request valid (held until acked) / accept pulse
//   req_type_i .. req_data_i : request fields (type, tid, addr, size, AMO op, data)
//   rtrn_val_o / rtrn_ack_i  : response valid / response consumed
//   rtrn_type_o, rtrn_tid_o, rtrn_data_o : response fields
// After every reset the array is swept to zero one line per cycle; no request
// is accepted until the sweep finishes.
module wt_mem_responder
    import wt_mem_resp_pkg::*;
#(
    parameter int unsigned AddrWidth  = 40,
    parameter int unsigned LineWidth  = 128,
    parameter int unsigned IFillWidth = 256,
    parameter int unsigned DepthLines = 256,
    parameter int unsigned Latency    = 4
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic                  req_val_i,
    output logic                  req_ack_o,
    input  logic [1:0]            req_type_i,
    input  logic [1:0]            req_tid_i,
    input  logic [AddrWidth-1:0]  req_addr_i,
    input  logic [1:0]            req_size_i,
    input  logic [1:0]            req_amo_op_i,
    input  logic [63:0]           req_data_i,
    output logic                  rtrn_val_o,
    input  logic                  rtrn_ack_i,
    output logic [1:0]            rtrn_type_o,
    output logic [1:0]            rtrn_tid_o,
    output logic [IFillWidth-1:0] rtrn_data_o
);

    localparam int unsigned OffBits = $clog2(LineWidth / 8);
    localparam int unsigned IdxBits = $clog2(DepthLines);
    localparam int unsigned CntBits = (Latency > 1) ? $clog2(Latency) : 1;

    state_e                state_q, state_d;
    wt_mem_req_t           req_q;
    logic [CntBits-1:0]    cnt_q;
    logic [IdxBits-1:0]    clr_idx_q;

    // FSM control strobes
    logic                  accept;
    logic                  access_lo;
    logic                  access_hi;
    logic                  rtrn_done;

    // Storage port
    logic [LineWidth-1:0]  mem [DepthLines];
    logic                  mem_we;
    logic [IdxBits-1:0]    mem_waddr;
    logic [LineWidth-1:0]  mem_wdata;
    logic [IdxBits-1:0]    rd_idx;
    logic [LineWidth-1:0]  line_rd;
    logic [LineWidth-1:0]  line_wr;

    // Word / lane datapath
    logic [IdxBits-1:0]    line_idx;
    logic [OffBits-4:0]    word_sel;
    logic [63:0]           old_word;
    logic [63:0]           lane_bits;
    logic [5:0]            amo_shift;
    logic [63:0]           amo_result;
    logic [63:0]           amo_word;
    logic [63:0]           store_word;
    logic [63:0]           amo_old;
    logic [IFillWidth-1:0] rtrn_data_lo;
    logic                  unused_addr;

    assign line_idx  = req_q.addr[OffBits +: IdxBits];
    assign word_sel  = req_q.addr[OffBits-1:3];
    assign unused_addr = ^req_q.addr;

    // IFILL fetches an even/odd line pair: even line first, odd line second.
    always_comb begin
        rd_idx = line_idx;
        if (state_q == ST_ACCESS_HI) begin
            rd_idx = {line_idx[IdxBits-1:1], 1'b1};
        end else if (req_q.rtype == REQ_IFILL) begin
            rd_idx = {line_idx[IdxBits-1:1], 1'b0};
        end
    end

    assign line_rd   = mem[rd_idx];
    assign old_word  = line_rd[{word_sel, 6'd0} +: 64];
    assign lane_bits = bit_mask(req_q.size, req_q.addr[2:0]);
    assign amo_shift = {lane_base(req_q.size, req_q.addr[2:0]), 3'b000};

    // The ALU works on values shifted down to bit 0; the result is shifted
    // back into the addressed lanes and merged with the untouched bytes.
    wt_mem_resp_amo_alu u_amo_alu (
        .op      (req_q.amo_op),
        .size    (req_q.size),
        .old_val (old_word >> amo_shift),
        .operand (req_q.data >> amo_shift),
        .result  (amo_result)
    );

    assign amo_word   = (old_word & ~lane_bits) | ((amo_result << amo_shift) & lane_bits);
    assign store_word = (old_word & ~lane_bits) | (req_q.data & lane_bits);
    assign amo_old    = old_word & lane_bits;

    always_comb begin
        line_wr = line_rd;
        line_wr[{word_sel, 6'd0} +: 64] = (req_q.rtype == REQ_AMO) ? amo_word : store_word;
    end

    always_comb begin
        rtrn_data_lo = '0;
        case (req_q.rtype)
            REQ_LOAD, REQ_IFILL: rtrn_data_lo = IFillWidth'(line_rd);
            REQ_AMO:             rtrn_data_lo = IFillWidth'(amo_old);
            default:             rtrn_data_lo = '0;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values regardless of statement order.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q <= ST_CLEAR;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        accept    = 1'b0;
        access_lo = 1'b0;
        access_hi = 1'b0;
        rtrn_done = 1'b0;
        mem_we    = 1'b0;
        mem_waddr = rd_idx;
        mem_wdata = line_wr;
        unique case (state_q)
            ST_CLEAR: begin
                mem_we    = 1'b1;
                mem_waddr = clr_idx_q;
                mem_wdata = '0;
                if (clr_idx_q == IdxBits'(DepthLines - 1)) begin
                    state_d = ST_IDLE;
                end
            end
            ST_IDLE: begin
                if (req_val_i) begin
                    accept  = 1'b1;
                    state_d = ST_WAIT;
                end
            end
            ST_WAIT: begin
                if (cnt_q == '0) begin
                    state_d = ST_ACCESS;
                end
            end
            ST_ACCESS: begin
                access_lo = 1'b1;
                state_d   = ST_RESP;
                case (req_q.rtype)
                    REQ_IFILL:          state_d = ST_ACCESS_HI;
                    REQ_STORE, REQ_AMO: mem_we  = 1'b1;
                    default:            mem_we  = 1'b0;
                endcase
            end
            ST_ACCESS_HI: begin
                access_hi = 1'b1;
                state_d   = ST_RESP;
            end
            ST_RESP: begin
                if (rtrn_ack_i) begin
                    rtrn_done = 1'b1;
                    state_d   = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            req_ack_o   <= 1'b0;
            req_q       <= '0;
            cnt_q       <= '0;
            clr_idx_q   <= '0;
            rtrn_val_o  <= 1'b0;
            rtrn_type_o <= 2'd0;
            rtrn_tid_o  <= 2'd0;
            rtrn_data_o <= '0;
        end else begin
            req_ack_o <= accept;

            if (state_q == ST_CLEAR) begin
                clr_idx_q <= clr_idx_q + IdxBits'(1);
            end

            if (accept) begin
                req_q.rtype  <= req_type_e'(req_type_i);
                req_q.tid    <= req_tid_i;
                req_q.addr   <= ReqAddrWidth'(req_addr_i);
                req_q.size   <= req_size_i;
                req_q.amo_op <= amo_op_e'(req_amo_op_i);
                req_q.data   <= req_data_i;
                cnt_q        <= CntBits'(Latency - 1);
            end else if (state_q == ST_WAIT && cnt_q != '0) begin
                cnt_q <= cnt_q - CntBits'(1);
            end

            if (access_lo) begin
                rtrn_type_o <= req_q.rtype;
                rtrn_tid_o  <= req_q.tid;
                rtrn_data_o <= rtrn_data_lo;
                if (req_q.rtype != REQ_IFILL) begin
                    rtrn_val_o <= 1'b1;
                end
            end

            if (access_hi) begin
                rtrn_data_o[IFillWidth-1 -: LineWidth] <= line_rd;
                rtrn_val_o <= 1'b1;
            end

            if (rtrn_done) begin
                rtrn_val_o <= 1'b0;
            end
        end
    end

    // NOTE: the storage array has no reset term; it is cleared by the
    // post-reset sweep through the normal write port, which keeps it
    // inferable as RAM.
    always_ff @(posedge clk_i) begin
        if (mem_we) begin
            mem[mem_waddr] <= mem_wdata;
        end
    end

endmodule

// File: tb/tb_wt_mem_responder.sv
// Self-checking bench for wt_mem_responder: a byte-level memory model produces
// the expected response for each request; expectations are queued when the
// request is accepted and compared when the response is handed back.
module tb_wt_mem_responder;
    import wt_mem_resp_pkg::*;

    localparam int Lat = 4;

    logic         clk = 1'b0;
    logic         rst;
    logic         req_val;
    logic         req_ack;
    logic [1:0]   req_type;
    logic [1:0]   req_tid;
    logic [39:0]  req_addr;
    logic [1:0]   req_size;
    logic [1:0]   req_amo_op;
    logic [63:0]  req_data;
    logic         rtrn_val;
    logic         rtrn_ack;
    logic [1:0]   rtrn_type;
    logic [1:0]   rtrn_tid;
    logic [255:0] rtrn_data;

    always #5 clk = ~clk;

    wt_mem_responder #(.Latency(Lat)) dut (
        .clk_i        (clk),
        .rst_i        (rst),
        .req_val_i    (req_val),
        .req_ack_o    (req_ack),
        .req_type_i   (req_type),
        .req_tid_i    (req_tid),
        .req_addr_i   (req_addr),
        .req_size_i   (req_size),
        .req_amo_op_i (req_amo_op),
        .req_data_i   (req_data),
        .rtrn_val_o   (rtrn_val),
        .rtrn_ack_i   (rtrn_ack),
        .rtrn_type_o  (rtrn_type),
        .rtrn_tid_o   (rtrn_tid),
        .rtrn_data_o  (rtrn_data)
    );

    typedef struct {
        logic [1:0]   rtype;
        logic [1:0]   tid;
        logic [255:0] data;
    } exp_t;

    exp_t       exp_q[$];
    int         n_cmp = 0;
    int         n_err = 0;
    logic [7:0] mdl [4096];

    task automatic check(input string tag, input logic [255:0] got, input logic [255:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [127:0] mdl_line(input int a);
        logic [127:0] l;
        int base;
        base = a & 'hff0;
        for (int i = 0; i < 16; i++) l[i*8 +: 8] = mdl[base + i];
        return l;
    endfunction

    // Applies the request to the model and returns the expected rtrn data.
    function automatic logic [255:0] mdl_apply(input logic [1:0] t, input logic [39:0] addr,
                                               input logic [1:0] size, input logic [1:0] op,
                                               input logic [63:0] data);
        int a, n, s, b;
        logic [63:0] oldv, opnd, newv;
        a = int'(addr[11:0]);
        n = 1 << size;
        s = a & ~(n - 1);
        oldv = '0;
        opnd = '0;
        case (t)
            2'd0: return {128'd0, mdl_line(a)};
            2'd1: begin
                b = a & 'hfe0;
                return {mdl_line(b + 16), mdl_line(b)};
            end
            2'd2: begin
                for (int i = 0; i < n; i++) mdl[s + i] = data[((s % 8) + i)*8 +: 8];
                return '0;
            end
            default: begin
                for (int i = 0; i < n; i++) begin
                    oldv[i*8 +: 8] = mdl[s + i];
                    opnd[i*8 +: 8] = data[((s % 8) + i)*8 +: 8];
                end
                case (op)
                    2'd0:    newv = opnd;
                    2'd1:    newv = oldv + opnd;
                    2'd2:    newv = oldv & opnd;
                    default: newv = oldv | opnd;
                endcase
                for (int i = 0; i < n; i++) mdl[s + i] = newv[i*8 +: 8];
                return {192'd0, oldv << ((s % 8) * 8)};
            end
        endcase
    endfunction

    // Drives a request, waits for its accept pulse and queues the expectation.
    task automatic issue(input logic [1:0] t, input logic [1:0] tid, input logic [39:0] addr,
                         input logic [1:0] size, input logic [1:0] op, input logic [63:0] data,
                         output int wait_n);
        exp_t e;
        req_type   = t;
        req_tid    = tid;
        req_addr   = addr;
        req_size   = size;
        req_amo_op = op;
        req_data   = data;
        req_val    = 1'b1;
        wait_n     = 0;
        while (!req_ack && wait_n < 2000) begin
            step();
            wait_n++;
        end
        req_val = 1'b0;
        if (!req_ack) begin
            check("ack_timeout", 0, 1);
        end else begin
            e.rtype = t;
            e.tid   = tid;
            e.data  = mdl_apply(t, addr, size, op, data);
            exp_q.push_back(e);
        end
    endtask

    // Waits for the response, optionally holds it off, then acknowledges and
    // compares against the head of the scoreboard.
    task automatic collect(input int hold, input bit pend);
        exp_t e;
        int   lat;
        lat = 0;
        if (exp_q.size() == 0) begin
            check("sb_empty", 0, 1);
            return;
        end
        e = exp_q[0];
        while (!rtrn_val && lat < 200) begin
            step();
            lat++;
        end
        if (!rtrn_val) begin
            check("rtrn_timeout", 0, 1);
            void'(exp_q.pop_front());
            return;
        end
        check("rtrn_lat", lat, (e.rtype == 2'd1) ? Lat + 2 : Lat + 1);
        for (int i = 0; i < hold; i++) begin
            check("hold_val", rtrn_val, 1);
            check("hold_data", rtrn_data, e.data);
            if (pend) check("hold_no_ack", req_ack, 0);
            step();
        end
        rtrn_ack = 1'b1;
        e = exp_q.pop_front();
        check("rtrn_type", rtrn_type, e.rtype);
        check("rtrn_tid", rtrn_tid, e.tid);
        check("rtrn_data", rtrn_data, e.data);
        if (pend) check("no_ack_in_hs", req_ack, 0);
        step();
        rtrn_ack = 1'b0;
        check("val_drop", rtrn_val, 0);
    endtask

    task automatic txn(input logic [1:0] t, input logic [1:0] tid, input logic [39:0] addr,
                       input logic [1:0] size, input logic [1:0] op, input logic [63:0] data);
        int w;
        issue(t, tid, addr, size, op, data, w);
        collect(0, 1'b0);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: bench did not finish in time");
        $fatal(1);
    end

    initial begin
        int   w;
        logic seen;
        for (int i = 0; i < 4096; i++) mdl[i] = 8'h00;
        rst = 1'b1; req_val = 1'b0; rtrn_ack = 1'b0;
        req_type = '0; req_tid = '0; req_addr = '0; req_size = '0; req_amo_op = '0; req_data = '0;
        repeat (3) step();
        check("rst_req_ack", req_ack, 0);
        check("rst_rtrn_val", rtrn_val, 0);
        check("rst_rtrn_type", rtrn_type, 0);
        check("rst_rtrn_tid", rtrn_tid, 0);
        check("rst_rtrn_data", rtrn_data, 0);
        rst = 1'b0;

        // Basic load of cleared storage, store then load back.
        txn(2'd0, 2'd1, 40'h40, 2'd0, 2'd0, 64'h0);
        txn(2'd2, 2'd2, 40'h48, 2'd3, 2'd0, 64'hdead_beef_0123_4567);
        txn(2'd0, 2'd3, 40'h40, 2'd0, 2'd0, 64'h0);

        // IFILL spanning an even/odd line pair.
        txn(2'd2, 2'd0, 40'h40, 2'd3, 2'd0, 64'ha);
        txn(2'd2, 2'd1, 40'h50, 2'd3, 2'd0, 64'hb);
        txn(2'd1, 2'd3, 40'h50, 2'd0, 2'd0, 64'h0);

        // AMO ADD wraps within 32 bits; neighbouring word untouched.
        txn(2'd2, 2'd0, 40'h48, 2'd2, 2'd0, 64'hffff_ffff);
        txn(2'd2, 2'd1, 40'h4c, 2'd2, 2'd0, 64'h1234_5678_0000_0000);
        txn(2'd3, 2'd2, 40'h48, 2'd2, 2'd1, 64'h1);
        txn(2'd0, 2'd3, 40'h40, 2'd0, 2'd0, 64'h0);

        // Misaligned AMO SWAP, AND/OR, byte store through address wrap.
        txn(2'd3, 2'd0, 40'h43, 2'd1, 2'd0, 64'h0000_0000_beef_0000);
        txn(2'd3, 2'd1, 40'h40, 2'd3, 2'd2, 64'hff00_ff00_ff00_ff00);
        txn(2'd3, 2'd2, 40'h44, 2'd2, 2'd3, 64'h8000_0001_0000_0000);
        txn(2'd2, 2'd3, 40'h1007, 2'd0, 2'd0, 64'h7700_0000_0000_0000);
        txn(2'd0, 2'd0, 40'h3f_0000_0000, 2'd0, 2'd0, 64'h0);

        // Randomised mix over a small set of lines with random upper bits.
        for (int i = 0; i < 24; i++) begin
            logic [39:0] a;
            a = {28'($urandom), 12'($urandom_range(0, 255))};
            txn(2'($urandom_range(0, 3)), 2'($urandom), a, 2'($urandom),
                2'($urandom), {$urandom, $urandom});
        end

        // Back-pressure: response held 10 cycles with another request pending.
        issue(2'd0, 2'd2, 40'h40, 2'd0, 2'd0, 64'h0, w);
        req_type = 2'd2; req_tid = 2'd1; req_addr = 40'h60; req_size = 2'd3;
        req_amo_op = 2'd0; req_data = 64'h0bad_cafe_0000_1111; req_val = 1'b1;
        collect(10, 1'b1);
        issue(2'd2, 2'd1, 40'h60, 2'd3, 2'd0, 64'h0bad_cafe_0000_1111, w);
        check("ack_gap", w, 1);
        collect(0, 1'b0);
        txn(2'd0, 2'd3, 40'h60, 2'd0, 2'd0, 64'h0);

        // Reset during WAIT of a store: no response, storage re-cleared.
        issue(2'd2, 2'd0, 40'h40, 2'd3, 2'd0, 64'h5555_5555_5555_5555, w);
        step();
        step();
        rst = 1'b1;
        step();
        check("midrst_req_ack", req_ack, 0);
        check("midrst_rtrn_val", rtrn_val, 0);
        rst = 1'b0;
        exp_q.delete();
        for (int i = 0; i < 4096; i++) mdl[i] = 8'h00;
        seen = 1'b0;
        for (int i = 0; i < 300; i++) begin
            seen |= rtrn_val;
            step();
        end
        check("no_rtrn_after_rst", seen, 0);
        txn(2'd0, 2'd1, 40'h40, 2'd0, 2'd0, 64'h0);
        txn(2'd1, 2'd2, 40'h50, 2'd0, 2'd0, 64'h0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
